mat_mul_engine: RTL and testbench

Parametrised, runtime-dimensioned matrix multiplier: computes O = A × B, with A sized R×K and B sized K×C. R, K and C are chosen per job up to compile-time maxima. Operands are loaded through a word-addressed write port into internal buffers, and a start/busy/done handshake launches each job. Results stream out in row-major order on a valid/ready port with backpressure, saturated to DW bits, with optional ReLU. It sits between the host/DMA loader and downstream layer logic, built around a single sequential MAC sub-module.

---
 rtl/mat_mul_engine_pkg.sv | 26 ++
 rtl/mat_mul_engine_if.sv | 46 ++++
 rtl/mat_mul_engine_mac_seq.sv | 24 ++
 rtl/mat_mul_engine.sv | 159 +++++++++++++++
 tb/tb_mat_mul_engine.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mat_mul_engine_pkg.sv
// Shared types and helpers for mat_mul_engine: FSM state, index-width helpers, saturation.
package mat_pkg;

  typedef enum logic [1:0] {IDLE, CALC, OUT, DONE} state_t;

  localparam int SAT_W = 128;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clamp a sign-extended accumulator into the signed dw-bit range; caller truncates to dw.
  function automatic logic signed [63:0] sat_dw(input logic signed [SAT_W-1:0] acc, input int dw);
    logic signed [SAT_W-1:0] hi, lo;
    hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (acc > hi)      return 64'(hi);
    else if (acc < lo) return 64'(lo);
    else               return 64'(acc);
  endfunction

endpackage

// File: rtl/mat_mul_engine_if.sv
// Operand load, job control and result stream bundle for mat_mul_engine.
interface mat_mul_engine_if
  import mat_pkg::*;
#(
  parameter int DW    = 32,
  parameter int MAX_R = 4,
  parameter int MAX_K = 16,
  parameter int MAX_C = 8
);
  localparam int WRW = $clog2(max2(MAX_R, MAX_K));
  localparam int WCW = $clog2(max2(MAX_K, MAX_C));
  localparam int RDW = $clog2(MAX_R + 1);
  localparam int KDW = $clog2(MAX_K + 1);
  localparam int CDW = $clog2(MAX_C + 1);
  localparam int RIW = idx_w(MAX_R);
  localparam int CIW = idx_w(MAX_C);

  logic                 wr_en;
  logic                 wr_sel;
  logic [WRW-1:0]       wr_row;
  logic [WCW-1:0]       wr_col;
  logic signed [DW-1:0] wr_data;
  logic [RDW-1:0]       cfg_r;
  logic [KDW-1:0]       cfg_k;
  logic [CDW-1:0]       cfg_c;
  logic                 relu;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 res_valid;
  logic                 res_ready;
  logic [RIW-1:0]       res_row;
  logic [CIW-1:0]       res_col;
  logic signed [DW-1:0] res_data;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, cfg_r, cfg_k, cfg_c, relu, start, res_ready,
    input  busy, done, err, res_valid, res_row, res_col, res_data
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, cfg_r, cfg_k, cfg_c, relu, start, res_ready,
    output busy, done, err, res_valid, res_row, res_col, res_data
  );
endinterface

// File: rtl/mat_mul_engine_mac_seq.sv
// Sequential signed multiply-accumulate: one DWxDW product per enabled cycle into ACCW bits.
module mac_seq #(
  parameter int DW   = 32,
  parameter int ACCW = 68
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);
  logic signed [2*DW-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (rst || clr)
      acc <= '0;
    else if (en)
      acc <= acc + ACCW'(prod);
  end
endmodule

// File: rtl/mat_mul_engine.sv
// Runtime-dimensioned O = A x B engine with saturated, backpressured row-major output.
// Optional feature macro: MAT_RELU_EN (honour the per-job relu input).
module mat_mul_engine
  import mat_pkg::*;
#(
  parameter int DW    = 32,
  parameter int MAX_R = 4,
  parameter int MAX_K = 16,
  parameter int MAX_C = 8,
  parameter int ACCW  = 2*DW + $clog2(MAX_K)
) (
  input logic             clk,
  input logic             rst,
  mat_mul_engine_if.slave io
);
  localparam int WRW = $clog2(max2(MAX_R, MAX_K));
  localparam int WCW = $clog2(max2(MAX_K, MAX_C));
  localparam int RDW = $clog2(MAX_R + 1);
  localparam int KDW = $clog2(MAX_K + 1);
  localparam int CDW = $clog2(MAX_C + 1);
  localparam int RIW = idx_w(MAX_R);
  localparam int KIW = idx_w(MAX_K);
  localparam int CIW = idx_w(MAX_C);

  logic signed [DW-1:0] a_buf [MAX_R][MAX_K];
  logic signed [DW-1:0] b_buf [MAX_K][MAX_C];

  state_t               state;
  logic [RIW-1:0]       i;
  logic [CIW-1:0]       j;
  logic [KIW-1:0]       t;
  logic [RDW-1:0]       r_q;
  logic [KDW-1:0]       k_q;
  logic [CDW-1:0]       c_q;
  logic                 busy, done, err, vld;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0] sat_v, res_v, op_a, op_b;
  logic                 hs, last_t, last_j, last_i, dims_ok, a_ok, b_ok, mac_clr, mac_en;

  // Range check uses the full index so out-of-range rows can't alias via truncation.
  assign a_ok = ({1'b0, io.wr_row} < (WRW+1)'(MAX_R)) && ({1'b0, io.wr_col} < (WCW+1)'(MAX_K));
  assign b_ok = ({1'b0, io.wr_row} < (WRW+1)'(MAX_K)) && ({1'b0, io.wr_col} < (WCW+1)'(MAX_C));

  always_ff @(posedge clk) begin
    if (io.wr_en && state == IDLE) begin
      if (!io.wr_sel && a_ok) a_buf[io.wr_row[RIW-1:0]][io.wr_col[KIW-1:0]] <= io.wr_data;
      if ( io.wr_sel && b_ok) b_buf[io.wr_row[KIW-1:0]][io.wr_col[CIW-1:0]] <= io.wr_data;
    end
  end

  assign dims_ok = (io.cfg_r != '0) && (io.cfg_r <= RDW'(MAX_R)) &&
                   (io.cfg_k != '0) && (io.cfg_k <= KDW'(MAX_K)) &&
                   (io.cfg_c != '0) && (io.cfg_c <= CDW'(MAX_C));
  assign last_t  = KDW'(t) == k_q - KDW'(1);
  assign last_j  = CDW'(j) == c_q - CDW'(1);
  assign last_i  = RDW'(i) == r_q - RDW'(1);
  assign hs      = (state == OUT) && vld && io.res_ready;
  assign mac_clr = (state == IDLE) || hs;
  assign mac_en  = (state == CALC);
  assign op_a    = a_buf[i][t];
  assign op_b    = b_buf[t][j];

  mac_seq #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk(clk), .rst(rst), .clr(mac_clr), .en(mac_en), .a(op_a), .b(op_b), .acc(acc)
  );

  assign sat_v = DW'(sat_dw(SAT_W'(acc), DW));

`ifdef MAT_RELU_EN
  logic relu_q;
  always_ff @(posedge clk) begin
    if (rst)                           relu_q <= 1'b0;
    else if (state == IDLE && io.start) relu_q <= io.relu;
  end
  assign res_v = (relu_q && sat_v[DW-1]) ? '0 : sat_v;
`else
  assign res_v = sat_v;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      vld   <= 1'b0;
      i     <= '0;
      j     <= '0;
      t     <= '0;
      r_q   <= '0;
      k_q   <= '0;
      c_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (io.start) begin
            r_q  <= io.cfg_r;
            k_q  <= io.cfg_k;
            c_q  <= io.cfg_c;
            i    <= '0;
            j    <= '0;
            t    <= '0;
            busy <= 1'b1;
            if (dims_ok) begin
              err   <= 1'b0;
              state <= CALC;
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        CALC: begin
          if (last_t) begin
            vld   <= 1'b1;
            state <= OUT;
          end else begin
            t <= t + KIW'(1);
          end
        end
        OUT: begin
          if (hs) begin
            vld <= 1'b0;
            t   <= '0;
            if (last_j) begin
              j <= '0;
              if (last_i) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                i     <= i + RIW'(1);
                state <= CALC;
              end
            end else begin
              j     <= j + CIW'(1);
              state <= CALC;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.busy      = busy;
  assign io.done      = done;
  assign io.err       = err;
  assign io.res_valid = vld;
  assign io.res_row   = i;
  assign io.res_col   = j;
  assign io.res_data  = vld ? res_v : '0;
endmodule

// File: tb/tb_mat_mul_engine.sv
// Directed bench for mat_mul_engine: 32-bit engine for function/timing, 16-bit engine for saturation.
module tb_mat_mul_engine;
  import mat_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mat_mul_engine_if #(.DW(32), .MAX_R(4), .MAX_K(16), .MAX_C(8)) bus ();
  mat_mul_engine_if #(.DW(16), .MAX_R(2), .MAX_K(2),  .MAX_C(2)) b16 ();

  mat_mul_engine #(.DW(32), .MAX_R(4), .MAX_K(16), .MAX_C(8)) u_dut (
    .clk(clk), .rst(rst), .io(bus.slave)
  );
  mat_mul_engine #(.DW(16), .MAX_R(2), .MAX_K(2), .MAX_C(2)) u_d16 (
    .clk(clk), .rst(rst), .io(b16.slave)
  );

  typedef struct {
    int         row;
    int         col;
    logic signed [63:0] data;
  } res_t;

  int   checks   = 0;
  int   failures = 0;
  res_t got[$];
  int   first_hs, done_edge;
  logic err_at_done, vld_at_done;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr32(input bit sel, input int row, input int col, input int d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_row = 4'(row); bus.wr_col = 4'(col); bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wr16(input bit sel, input int row, input int col, input int d);
    @(negedge clk);
    b16.wr_en = 1'b1; b16.wr_sel = sel; b16.wr_row = 1'(row); b16.wr_col = 1'(col); b16.wr_data = 16'(d);
    @(negedge clk);
    b16.wr_en = 1'b0;
  endtask

  // Edge numbering: E0 is the edge that samples start; e counts edges after E0.
  task automatic run_job(input int r, input int k, input int c, input bit rl, input bit stall, input int budget);
    int   e;
    bit   rdy, held;
    logic signed [63:0] hd;
    int   hr, hc;
    got.delete();
    first_hs = -1; done_edge = -1; held = 0; hd = 0; hr = 0; hc = 0;
    @(negedge clk);
    bus.cfg_r = 3'(r); bus.cfg_k = 5'(k); bus.cfg_c = 4'(c); bus.relu = rl;
    bus.start = 1'b1; bus.res_ready = 1'b0;
    @(posedge clk);
    e = 0;
    while (1) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        done_edge = e; err_at_done = bus.err; vld_at_done = bus.res_valid;
        break;
      end
      if (e >= budget) begin
        checks++; failures++;
        $display("FAIL job_timeout: no done after %0d cycles", e);
        break;
      end
      if (held) begin
        chk("stall_valid", bus.res_valid, 1);
        chk("stall_data", bus.res_data, hd);
        chk("stall_row", bus.res_row, hr);
        chk("stall_col", bus.res_col, hc);
      end
      rdy = stall ? (e % 3 == 2) : 1'b1;
      bus.res_ready = rdy;
      held = 0;
      if (bus.res_valid) begin
        if (rdy) begin
          got.push_back('{bus.res_row, bus.res_col, bus.res_data});
          if (first_hs < 0) first_hs = e + 1;
        end else begin
          held = 1; hd = bus.res_data; hr = bus.res_row; hc = bus.res_col;
        end
      end
      @(posedge clk);
      e++;
    end
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_after_done", bus.busy, 0);
  endtask

  task automatic run16(input logic signed [63:0] exp, input string name);
    int   e;
    bit   seen;
    @(negedge clk);
    b16.cfg_r = 2'd1; b16.cfg_k = 2'd2; b16.cfg_c = 2'd1; b16.start = 1'b1; b16.res_ready = 1'b1;
    seen = 0;
    for (e = 0; e < 50 && !b16.done; e++) begin
      @(negedge clk);
      b16.start = 1'b0;
      if (b16.res_valid && !seen) begin
        seen = 1;
        chk(name, b16.res_data, exp);
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout: no result within %0d cycles", name, e);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_job1(input string tag);
    res_t tbl[4];
    tbl[0] = '{0, 0, 58};
    tbl[1] = '{0, 1, 64};
    tbl[2] = '{1, 0, 139};
    tbl[3] = '{1, 1, 154};
    chk({tag, "_count"}, got.size(), 4);
    for (int n = 0; n < 4 && n < got.size(); n++) begin
      chk($sformatf("%s_row%0d", tag, n), got[n].row, tbl[n].row);
      chk($sformatf("%s_col%0d", tag, n), got[n].col, tbl[n].col);
      chk($sformatf("%s_data%0d", tag, n), got[n].data, tbl[n].data);
    end
    chk({tag, "_err"}, err_at_done, 0);
  endtask

  initial begin
    int a_init[2][3];
    int b_init[3][2];
    bit saw_done;
    a_init = '{'{1, 2, 3}, '{4, 5, 6}};
    b_init = '{'{7, 8}, '{9, 10}, '{11, 12}};

    bus.wr_en = 0; bus.wr_sel = 0; bus.wr_row = 0; bus.wr_col = 0; bus.wr_data = 0;
    bus.cfg_r = 3'd2; bus.cfg_k = 5'd3; bus.cfg_c = 4'd2; bus.relu = 0; bus.res_ready = 1;
    b16.wr_en = 0; b16.wr_sel = 0; b16.wr_row = 0; b16.wr_col = 0; b16.wr_data = 0;
    b16.cfg_r = 0; b16.cfg_k = 0; b16.cfg_c = 0; b16.relu = 0; b16.res_ready = 1; b16.start = 0;
    // start held together with rst: reset must win
    bus.start = 1;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_row", bus.res_row, 0);
    chk("rst_col", bus.res_col, 0);
    chk("rst_data", bus.res_data, 0);
    bus.start = 0;
    rst = 0;
    @(negedge clk);
    chk("start_with_rst_ignored", bus.busy, 0);

    for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) wr32(0, r, c, a_init[r][c]);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 2; c++) wr32(1, r, c, b_init[r][c]);
    wr32(0, 4, 0, 99);  // row 4 is out of range for A and must not touch A[0][0]

    run_job(2, 3, 2, 0, 0, 100);
    check_job1("job1");
    chk("job1_first_hs_edge", first_hs, 4);
    chk("job1_done_edge", done_edge, 2*2*(3+1));

    run_job(2, 3, 2, 0, 1, 200);
    check_job1("stall");

    run_job(2, 0, 2, 0, 0, 20);
    chk("bad_k_err", err_at_done, 1);
    chk("bad_k_done_edge", done_edge, 0);
    chk("bad_k_valid", vld_at_done, 0);
    chk("bad_k_results", got.size(), 0);
    chk("err_sticky", bus.err, 1);

    run_job(2, 3, 2, 0, 0, 100);
    check_job1("after_err");

    // Reset in CALC of element (0,1): E4 handshakes (0,0), E5 is its first term.
    @(negedge clk);
    bus.cfg_r = 3'd2; bus.cfg_k = 5'd3; bus.cfg_c = 4'd2; bus.start = 1; bus.res_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    chk("pre_rst_col", bus.res_col, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_valid", bus.res_valid, 0);
    chk("midrst_data", bus.res_data, 0);
    chk("midrst_col", bus.res_col, 0);
    chk("midrst_done", bus.done, 0);
    saw_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.res_valid) saw_done = 1;
    end
    chk("midrst_quiet", saw_done, 0);
    run_job(2, 3, 2, 0, 0, 100);
    check_job1("post_rst");

    wr16(0, 0, 0, 32767); wr16(0, 0, 1, 32767);
    wr16(1, 0, 0, 32767); wr16(1, 1, 0, 32767);
    run16(64'sd32767, "sat_pos");
    wr16(0, 0, 0, -32767); wr16(0, 0, 1, -32767);
    run16(-64'sd32768, "sat_neg");

    wr32(0, 0, 0, -1); wr32(0, 0, 1, -2);
    wr32(1, 0, 0, 3);  wr32(1, 1, 0, 4);
    run_job(1, 2, 1, 1, 0, 50);
    chk("relu1_count", got.size(), 1);
`ifdef MAT_RELU_EN
    if (got.size() > 0) chk("relu1_data", got[0].data, 0);
`else
    if (got.size() > 0) chk("relu1_ignored_data", got[0].data, -11);
`endif
    run_job(1, 2, 1, 0, 0, 50);
    chk("relu0_count", got.size(), 1);
    if (got.size() > 0) chk("relu0_data", got[0].data, -11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
